// File: rtl/rv_axi_write_adapter_if.sv
// rtl/rv_axi_write_adapter_if.sv - request, AXI4 write (AW/W/B) and response signal bundle
interface rv_axi_write_adapter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 1
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_data;
   logic [STRB_WIDTH-1:0] req_strb;

   logic                  AWVALID;
   logic                  AWREADY;
   logic [ADDR_WIDTH-1:0] AWADDR;
   logic [7:0]            AWLEN;
   logic [2:0]            AWSIZE;
   logic [1:0]            AWBURST;
   logic [3:0]            AWCACHE;
   logic                  AWLOCK;
   logic [2:0]            AWPROT;
   logic [3:0]            AWQOS;
   logic [ID_WIDTH-1:0]   AWID;
   logic                  AWUSER;

   logic                  WVALID;
   logic                  WREADY;
   logic [DATA_WIDTH-1:0] WDATA;
   logic [STRB_WIDTH-1:0] WSTRB;
   logic                  WLAST;

   logic                  BVALID;
   logic                  BREADY;
   logic [1:0]            BRESP;
   logic [ID_WIDTH-1:0]   BID;

   logic                  resp_valid;
   logic                  resp_ready;
   logic                  resp_error;

   // master: the adapter's view; slave: the core and interconnect around it
   modport master (
      input  req_valid, req_addr, req_data, req_strb,
      output req_ready,
      output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE, AWLOCK, AWPROT, AWQOS, AWID, AWUSER,
      input  AWREADY,
      output WVALID, WDATA, WSTRB, WLAST,
      input  WREADY,
      input  BVALID, BRESP, BID,
      output BREADY,
      output resp_valid, resp_error,
      input  resp_ready
   );

   modport slave (
      output req_valid, req_addr, req_data, req_strb,
      input  req_ready,
      input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE, AWLOCK, AWPROT, AWQOS, AWID, AWUSER,
      output AWREADY,
      input  WVALID, WDATA, WSTRB, WLAST,
      output WREADY,
      output BVALID, BRESP, BID,
      input  BREADY,
      input  resp_valid, resp_error,
      output resp_ready
   );
endinterface

// File: rtl/rv_axi_write_adapter.sv
// rtl/rv_axi_write_adapter.sv - single-word write requests to AXI4 single-beat writes, in-order responses
module rv_axi_write_adapter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int ID_WIDTH        = 1,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   rv_axi_write_adapter_if.master  bus
);
   localparam int                   STRB_WIDTH = DATA_WIDTH / 8;
   localparam int                   CNT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = CNT_WIDTH'(MAX_OUTSTANDING);
   localparam logic [2:0]           AXI_SIZE   = 3'($clog2(STRB_WIDTH));

   // Which of the AW/W halves of the current write are still waiting for their handshake
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BOTH,
      ST_AW_ONLY,
      ST_W_ONLY
   } chan_state_t;

   chan_state_t           state_q;
   chan_state_t           state_d;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic [CNT_WIDTH-1:0]  count_q;
   logic                  resp_valid_q;
   logic                  resp_error_q;

   logic                  aw_busy;
   logic                  w_busy;
   logic                  req_ready;
   logic                  accept;
   logic                  bready;
   logic                  b_fire;
   logic                  unused_inputs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      aw_busy = 1'b0;
      w_busy  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_BOTH;
            end
         end
         ST_BOTH: begin
            aw_busy = 1'b1;
            w_busy  = 1'b1;
            if (bus.AWREADY && bus.WREADY) begin
               state_d = ST_IDLE;
            end else if (bus.AWREADY) begin
               state_d = ST_W_ONLY;
            end else if (bus.WREADY) begin
               state_d = ST_AW_ONLY;
            end
         end
         ST_AW_ONLY: begin
            aw_busy = 1'b1;
            if (bus.AWREADY) begin
               state_d = ST_IDLE;
            end
         end
         ST_W_ONLY: begin
            w_busy = 1'b1;
            if (bus.WREADY) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req_ready = !aw_busy && !w_busy && (count_q < CNT_MAX) && !rst;
   assign accept    = bus.req_valid && req_ready;

   // Payload is only loaded while both channels are idle, so it stays stable under valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else if (accept) begin
         awaddr_q <= bus.req_addr;
         wdata_q  <= bus.req_data;
         wstrb_q  <= bus.req_strb;
      end
   end

   assign bready = !resp_valid_q || bus.resp_ready;
   assign b_fire = bus.BVALID && bready;

   // A spurious B with nothing outstanding leaves the count at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (accept && !b_fire) begin
         count_q <= count_q + 1'b1;
      end else if (b_fire && !accept && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
      end else if (b_fire) begin
         resp_valid_q <= 1'b1;
         resp_error_q <= bus.BRESP[1];
      end else if (bus.resp_ready) begin
         resp_valid_q <= 1'b0;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.AWVALID    = aw_busy;
   assign bus.AWADDR     = awaddr_q;
   assign bus.AWLEN      = 8'd0;
   assign bus.AWSIZE     = AXI_SIZE;
   assign bus.AWBURST    = 2'b01;
   assign bus.AWCACHE    = 4'b0011;
   assign bus.AWLOCK     = 1'b0;
   assign bus.AWPROT     = 3'b000;
   assign bus.AWQOS      = 4'd0;
   assign bus.AWID       = '0;
   assign bus.AWUSER     = 1'b0;
   assign bus.WVALID     = w_busy;
   assign bus.WDATA      = wdata_q;
   assign bus.WSTRB      = wstrb_q;
   assign bus.WLAST      = 1'b1;
   assign bus.BREADY     = bready;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_error = resp_error_q;

   // Single fixed ID, and OKAY/EXOKAY are both treated as success
   assign unused_inputs = ^{bus.BID, bus.BRESP[0]};

   bvalid_needs_outstanding: assert property (
      @(posedge clk) disable iff (rst) bus.BVALID |-> (count_q != '0)
   );
endmodule
